// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART serializer between NUM_REQ byte producers.
// A grant is held across a multi-byte message so messages never interleave on the line.
`timescale 1ns / 1ps
module uart_tx_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                 i_uart_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_valid,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_busy,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitAct  = 3'd2,
    StWaitDone = 3'd3,
    StWaitClr  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_valid_q, tx_valid_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              lock_q, lock_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [ID_W-1:0]   sel;
  logic              sel_vld;
  logic              accept;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NUM_REQ;
    return ID_W'(s);
  endfunction

  // A locked grant makes only the current owner eligible; otherwise scan from the pointer.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (lock_q) begin
      sel     = grant_q;
      sel_vld = i_req_valid[grant_q];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!sel_vld && i_req_valid[rr_idx(ptr_q, i)]) begin
          sel     = rr_idx(ptr_q, i);
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign accept = (state_q == StIdle) && sel_vld;

  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready = NUM_REQ'(1) << sel;
  end

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    grant_d    = grant_q;
    err_d      = 1'b0;
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          tx_byte_d  = i_req_data[{sel, 3'b000} +: 8];
          grant_d    = sel;
          lock_d     = ~i_req_last[sel];
          if (i_req_last[sel]) ptr_d = rr_idx(sel, 1);
          tx_valid_d = 1'b1;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitAct;
      end
      StWaitAct: begin
        if (i_tx_active) begin
          state_d = StWaitDone;
        end else if ({1'b0, cnt_q} + 17'd1 == 17'(TIMEOUT_CYCLES)) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = rr_idx(grant_q, 1);
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitDone: begin
        if (i_tx_done) state_d = StWaitClr;
      end
      StWaitClr: begin
        if (!i_tx_done) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        tx_byte_d = '0;
        grant_d   = '0;
        ptr_d     = '0;
        lock_d    = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      grant_q    <= '0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      grant_q    <= grant_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_tx_byte  = tx_byte_q;
  assign o_tx_valid = tx_valid_q;
  assign o_grant_id = grant_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a one-cycle-per-bit transmitter stub.
`timescale 1ns / 1ps
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_active;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;
  int err_cnt = 0;

  logic       stub_en;
  int         st_cnt;
  logic [7:0] shreg;
  logic       line;
  logic [7:0] issued[$];
  logic [1:0] grants[$];
  logic       line_log[$];

  uart_tx_sched #(
    .NUM_REQ       (4),
    .ID_W          (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_uart_clk (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .i_req_data (req_data),
    .i_req_last (req_last),
    .o_req_ready(req_ready),
    .o_tx_byte  (tx_byte),
    .o_tx_valid (tx_valid),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .o_grant_id (grant_id),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  // Transmitter stub: start bit, 8 data bits LSB first, one stop bit with done high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt    <= 0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      line      <= 1'b1;
      shreg     <= '0;
    end else if (st_cnt == 0) begin
      if (tx_valid && stub_en) begin
        st_cnt    <= 1;
        tx_active <= 1'b1;
        line      <= 1'b0;
        shreg     <= tx_byte;
      end
    end else if (st_cnt <= 8) begin
      line   <= shreg[st_cnt-1];
      st_cnt <= st_cnt + 1;
    end else if (st_cnt == 9) begin
      tx_active <= 1'b0;
      tx_done   <= 1'b1;
      line      <= 1'b1;
      st_cnt    <= 10;
    end else begin
      tx_done <= 1'b0;
      st_cnt  <= 0;
    end
  end

  always @(negedge clk) begin
    if (tx_valid) begin
      issued.push_back(tx_byte);
      grants.push_back(grant_id);
    end
    if (tx_active || tx_done) line_log.push_back(line);
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[8*k +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [9:0] frame;
    int         bad;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    stub_en   = 1'b1;
    tick();
    tick();
    check("rst_tx_byte", {24'd0, tx_byte}, 32'h0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("rst_grant", {30'd0, grant_id}, 32'h0);
    check("rst_busy_err", {30'd0, busy, err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: single byte from req0, check serial framing
    line_log.delete();
    set_req(0, 1'b1, 8'hA5, 1'b1);
    #1;
    check("t1_ready", {28'd0, req_ready}, 32'h1);
    tick();
    set_req(0, 1'b0, 8'h00, 1'b0);
    check("t1_issue", {22'd0, tx_valid, busy, tx_byte}, {22'd0, 2'b11, 8'hA5});
    tick();
    check("t1_pulse_one", {31'd0, tx_valid}, 32'h0);
    wait_idle("t1_idle");
    check("t1_line_len", line_log.size(), 32'd10);
    for (int i = 0; i < 10; i++) frame[i] = line_log[i];
    check("t1_line_bits", {22'd0, frame}, {22'd0, 1'b1, 8'hA5, 1'b0});
    check("t1_byte_hold", {24'd0, tx_byte}, 32'hA5);

    // 2: req1 and req3 compete every cycle, expect alternation
    issued.delete();
    grants.delete();
    set_req(1, 1'b1, 8'h11, 1'b1);
    set_req(3, 1'b1, 8'h33, 1'b1);
    for (int i = 0; i < 100 && issued.size() < 3; i++) tick();
    req_valid = '0;
    check("t2_count", issued.size(), 32'd3);
    check("t2_bytes", {8'd0, issued[0], issued[1], issued[2]}, 32'h00113311);
    check("t2_grants", {26'd0, grants[0], grants[1], grants[2]}, {26'd0, 6'b01_11_01});
    wait_idle("t2_idle");

    // 3: two-byte message from req2 holds off req0
    issued.delete();
    set_req(0, 1'b1, 8'h30, 1'b1);
    set_req(2, 1'b1, 8'h48, 1'b0);
    #1;
    check("t3_ready_first", {28'd0, req_ready}, 32'h4);
    tick();
    set_req(2, 1'b1, 8'h49, 1'b1);
    for (int i = 0; i < 40 && !req_ready[2]; i++) tick();
    check("t3_locked_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 60 && issued.size() < 3; i++) tick();
    req_valid[0] = 1'b0;
    check("t3_order", {8'd0, issued[0], issued[1], issued[2]}, 32'h00484930);
    wait_idle("t3_idle");

    // 4: transmitter never answers, issue times out after 8 waiting cycles
    stub_en = 1'b0;
    set_req(1, 1'b1, 8'h77, 1'b0);
    set_req(2, 1'b1, 8'h22, 1'b1);
    #1;
    check("t4_ready", {28'd0, req_ready}, 32'h2);
    tick();
    check("t4_issue", {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, 8'h77});
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t4_no_err_yet", {31'd0, err}, 32'h0);
    end
    tick();
    check("t4_err_pulse", {30'd0, err, busy}, {30'd0, 2'b10});
    check("t4_next_req", {28'd0, req_ready}, 32'h4);
    stub_en = 1'b1;
    tick();
    req_valid = '0;
    check("t4_reissue", {21'd0, tx_valid, grant_id, tx_byte}, {21'd0, 1'b1, 2'd2, 8'h22});
    tick();
    check("t4_err_once", {31'd0, err}, 32'h0);
    wait_idle("t4_idle");

    // 5: asynchronous reset during WAIT_DONE
    set_req(0, 1'b1, 8'h99, 1'b0);
    #1;
    check("t5_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    check("t5_busy", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_async_rst", {19'd0, tx_byte, tx_valid, grant_id, busy, err},
          {19'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    set_req(3, 1'b1, 8'h3C, 1'b1);
    #1;
    check("t5_lock_cleared", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid[3] = 1'b0;
    check("t5_req3", {22'd0, grant_id, tx_byte}, {22'd0, 2'd3, 8'h3C});
    wait_idle("t5_idle_a");
    set_req(0, 1'b1, 8'h5A, 1'b1);
    #1;
    check("t5_ready0", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    check("t5_req0", {21'd0, tx_valid, grant_id, tx_byte}, {21'd0, 1'b1, 2'd0, 8'h5A});
    wait_idle("t5_idle_b");

    // 6: locked owner goes quiet, others must wait without timeout
    issued.delete();
    set_req(1, 1'b1, 8'h41, 1'b0);
    #1;
    check("t6_ready1", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 8'h07, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (req_ready[0]) bad++;
    end
    check("t6_no_starve_leak", bad, 32'd0);
    check("t6_hold", {29'd0, grant_id, busy}, {29'd0, 2'd1, 1'b0});
    set_req(1, 1'b1, 8'h42, 1'b1);
    #1;
    check("t6_ready_owner", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid[1] = 1'b0;
    wait_idle("t6_idle_a");
    #1;
    check("t6_ready0", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid[0] = 1'b0;
    wait_idle("t6_idle_b");
    check("t6_order", {8'd0, issued[0], issued[1], issued[2]}, 32'h00414207);
    check("err_total", err_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish within 200us");
    $fatal(1);
  end

endmodule
